pipe_stage_skid: RTL

- Generic, parametrised inter-stage pipeline register for the 5-stage core. It replaces hand-written per-stage latches such as decode/execute and execute/memory.
- Carries a control bundle and a data payload between stages with a valid/ready handshake, synchronous flush and bubble insertion.
- Has an optional 2-entry skid buffer so the downstream stall does not propagate combinationally into the upstream stage.

---
 rtl/pipe_pkg.sv | 62 ++++++
 rtl/pipe_entry_reg.sv | 58 +++++
 rtl/pipe_stage_skid.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the inter-stage pipeline registers of the 5-stage
//   core: per-stage control/payload widths, the control value each stage
//   presents while it holds a bubble, and packed control-bundle typedefs so
//   stage tops can pack/unpack the bundles by field name.
// -----------------------------------------------------------------------------
package pipe_pkg;

  // Decode -> Execute
  localparam int DE_CTRL_W = 24;
  localparam int DE_DATA_W = 96;  // {RD1, RD2, SIGN_IMM}

  // Execute -> Memory
  localparam int EM_CTRL_W = 8;
  localparam int EM_DATA_W = 64;  // {ALU_OUT, WRITE_DATA}

  // Memory -> Writeback
  localparam int MW_CTRL_W = 7;
  localparam int MW_DATA_W = 64;  // {READ_DATA, ALU_OUT}

  // Decode/execute control bundle. alu_ctrl sits in bits [3:0].
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [3:0] alu_ctrl;
  } de_ctrl_t;

  // Execute/memory control bundle.
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic [4:0] write_reg;
  } em_ctrl_t;

  // Memory/writeback control bundle.
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] write_reg;
  } mw_ctrl_t;

  // Bubble values: no register/memory writes anywhere. The decode/execute
  // bubble additionally selects the otherwise unused ALU opcode 4'b1111.
  localparam logic [DE_CTRL_W-1:0] DE_BUBBLE_CTRL = 24'h00000F;
  localparam logic [EM_CTRL_W-1:0] EM_BUBBLE_CTRL = 8'h00;
  localparam logic [MW_CTRL_W-1:0] MW_BUBBLE_CTRL = 7'h00;

  // Number of held entries, from the two slot valid bits.
  function automatic logic [1:0] occ_count(input logic main_vld,
                                           input logic skid_vld);
    return {1'b0, main_vld} + {1'b0, skid_vld};
  endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// -----------------------------------------------------------------------------
// pipe_entry_reg
//   One storage slot of a pipeline stage: a valid bit plus a control bundle
//   and payload register. Updates on the falling edge of CLK.
//
// Ports
//   CLK      in   stage clock (falling-edge active)
//   CLR      in   asynchronous active-high reset; clears valid and contents
//   clear_i  in   synchronous clear of the valid bit (wins over load_i)
//   load_i   in   capture ctrl_i/data_i and mark the slot valid
//   ctrl_i   in   control bundle to capture
//   data_i   in   payload to capture
//   vld_o    out  slot holds an entry
//   ctrl_o   out  stored control bundle (raw, not bubble-masked)
//   data_o   out  stored payload (raw, not bubble-masked)
// -----------------------------------------------------------------------------
import pipe_pkg::*;

module pipe_entry_reg #(
  parameter int CTRL_W = DE_CTRL_W,
  parameter int DATA_W = DE_DATA_W
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              vld_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              vld_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // A synchronous clear only drops the valid bit; the stale contents are
  // harmless because the stage masks its outputs with the valid bit.
  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR) begin
      vld_q  <= 1'b0;
      ctrl_q <= '0;
      data_q <= '0;
    end else if (clear_i) begin
      vld_q  <= 1'b0;
    end else if (load_i) begin
      vld_q  <= 1'b1;
      ctrl_q <= ctrl_i;
      data_q <= data_i;
    end
  end

  assign vld_o  = vld_q;
  assign ctrl_o = ctrl_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   Generic inter-stage pipeline register with valid/ready handshake,
//   synchronous flush, bubble masking and an optional 2-entry skid buffer.
//   All state updates on the falling edge of CLK.
//
// Ports
//   CLK        in   stage clock (falling-edge active)
//   CLR        in   asynchronous active-high reset
//   FLUSH      in   synchronous flush, drops every held and offered entry
//   IN_VALID   in   upstream entry valid
//   IN_READY   out  stage accepts an entry this cycle
//   IN_CTRL    in   upstream control bundle
//   IN_DATA    in   upstream payload
//   OUT_VALID  out  downstream entry valid
//   OUT_READY  in   downstream accepts (low = stall)
//   OUT_CTRL   out  control to next stage, BUBBLE_CTRL when OUT_VALID=0
//   OUT_DATA   out  payload to next stage, zero when OUT_VALID=0
//   OCCUPANCY  out  number of held entries (0..2)
//
// Parameters
//   SKID = 1: main + skid slot, IN_READY depends only on registered state.
//   SKID = 0: main slot only, IN_READY = !main_valid | OUT_READY.
// -----------------------------------------------------------------------------
import pipe_pkg::*;

module pipe_stage_skid #(
  parameter int                DATA_W      = DE_DATA_W,
  parameter int                CTRL_W      = DE_CTRL_W,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = DE_BUBBLE_CTRL,
  parameter bit                SKID        = 1'b1
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              FLUSH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [CTRL_W-1:0] IN_CTRL,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [CTRL_W-1:0] OUT_CTRL,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic [1:0]        OCCUPANCY
);

  // Slot state
  logic              main_vld_q;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [DATA_W-1:0] main_data_q;
  logic              skid_vld_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;

  // Next-state controls
  logic              main_load_d;
  logic              main_clr_d;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] main_data_d;
  logic              skid_load_d;
  logic              skid_clr_d;

  // Handshake
  logic in_rdy;
  logic acc;
  logic pop;
  logic main_free;

  assign pop = main_vld_q & OUT_READY;
  assign acc = IN_VALID & in_rdy;

  // Main slot may take new content this edge if it is empty or being popped.
  assign main_free = ~main_vld_q | pop;

  generate
    if (SKID) begin : g_skid
      // Ready derives only from the skid valid flop, so a downstream stall
      // never reaches the upstream stage combinationally. While the skid
      // slot is empty there is always room for one more entry.
      assign in_rdy = ~skid_vld_q;

      pipe_entry_reg #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
      ) u_skid (
        .CLK     (CLK),
        .CLR     (CLR),
        .clear_i (skid_clr_d),
        .load_i  (skid_load_d),
        .ctrl_i  (IN_CTRL),
        .data_i  (IN_DATA),
        .vld_o   (skid_vld_q),
        .ctrl_o  (skid_ctrl_q),
        .data_o  (skid_data_q)
      );
    end else begin : g_noskid
      assign in_rdy      = main_free;
      assign skid_vld_q  = 1'b0;
      assign skid_ctrl_q = '0;
      assign skid_data_q = '0;
    end
  endgenerate

  // Slot sequencing. The skid slot is only ever non-empty while main is
  // full, so it always holds the younger entry and refills main first.
  always_comb begin
    main_load_d = 1'b0;
    main_clr_d  = FLUSH;
    main_ctrl_d = IN_CTRL;
    main_data_d = IN_DATA;
    skid_load_d = 1'b0;
    skid_clr_d  = FLUSH;

    if (!FLUSH) begin
      if (main_free) begin
        if (skid_vld_q) begin
          // TWO + pop: skid advances into main; acc cannot occur here.
          main_load_d = 1'b1;
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
          skid_clr_d  = 1'b1;
        end else if (acc) begin
          // EMPTY + acc, or ONE + acc + pop: upstream entry goes to main.
          main_load_d = 1'b1;
        end else if (main_vld_q) begin
          // ONE + pop with nothing arriving.
          main_clr_d  = 1'b1;
        end
      end else if (acc) begin
        // ONE + acc while stalled: park the entry in the skid slot.
        skid_load_d = 1'b1;
      end
    end
  end

  pipe_entry_reg #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .CLK     (CLK),
    .CLR     (CLR),
    .clear_i (main_clr_d),
    .load_i  (main_load_d),
    .ctrl_i  (main_ctrl_d),
    .data_i  (main_data_d),
    .vld_o   (main_vld_q),
    .ctrl_o  (main_ctrl_q),
    .data_o  (main_data_q)
  );

  // Outputs are masked by the valid bit so a stale entry can never cause a
  // register or memory write in the next stage.
  assign IN_READY  = in_rdy;
  assign OUT_VALID = main_vld_q;
  assign OUT_CTRL  = main_vld_q ? main_ctrl_q : BUBBLE_CTRL;
  assign OUT_DATA  = main_vld_q ? main_data_q : '0;
  assign OCCUPANCY = occ_count(main_vld_q, skid_vld_q);

endmodule
